// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the icache and dcache controllers, one word per grant.
// Latency: 2 cycles minimum from request to wait low (IDLE decision cycle, then the grant cycle).
// Backpressure: the ramready handshake; the losing requester sees wait=1 and holds its request.
//
// Optional feature macro: MEM_ARBITER_PERF_EN adds the icyc_wait/dcyc_wait stall counters.
//
// Ports:
//   CLK, RST                  rising-edge clock, asynchronous active-high reset
//   iREN, iaddr               icache read request and word address
//   iload, iwait              icache read data / hold indication
//   dREN, dWEN, daddr, dstore dcache read/write request, address, write data
//   dload, dwait              dcache read data / hold indication
//   ramREN, ramWEN            RAM read/write strobes (combinational from grant state)
//   ramaddr, ramstore         RAM address and write data
//   ramload, ramready         RAM read data and access-complete indication
//   icyc_wait, dcyc_wait      (MEM_ARBITER_PERF_EN only) cycles each side spent waiting

module mem_arbiter #(
   parameter int unsigned WORD_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic [WORD_W-1:0] iload,
   output logic              iwait,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic [WORD_W-1:0] dload,
   output logic              dwait,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
`ifdef MEM_ARBITER_PERF_EN
   output logic [31:0]       icyc_wait,
   output logic [31:0]       dcyc_wait,
`endif
   input  logic [WORD_W-1:0] ramload,
   input  logic              ramready
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DRD  = 2'd2,
      DWR  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             starve_max;

   assign starve_max = (starve_q == CNT_W'(STARVE_LIMIT));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // All RAM strobes and requester responses are decoded from the registered
   // grant plus the live request, so a dropped request or a reset removes the
   // strobe in the same cycle without waiting for a clock edge.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;

      case (state_q)
         IDLE: begin
            // No icache demand means nobody is being starved.
            if (!iREN) begin
               starve_d = '0;
            end
            if (iREN && starve_max) begin
               state_d = IGNT;
            end else if (dWEN) begin
               state_d = DWR;
            end else if (dREN) begin
               state_d = DRD;
            end else if (iREN) begin
               state_d = IGNT;
            end
         end

         IGNT: begin
            if (iREN) begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (ramready) begin
                  iwait    = 1'b0;
                  iload    = ramload;
                  starve_d = '0;
                  state_d  = IDLE;
               end
            end else begin
               state_d = IDLE;
            end
         end

         DRD: begin
            // A write appearing mid-read is a different request: abort and re-arbitrate.
            if (dREN && !dWEN) begin
               ramREN  = 1'b1;
               ramaddr = daddr;
               if (ramready) begin
                  dwait   = 1'b0;
                  dload   = ramload;
                  state_d = IDLE;
                  if (iREN && !starve_max) begin
                     starve_d = starve_q + CNT_W'(1);
                  end
               end
            end else begin
               state_d = IDLE;
            end
         end

         DWR: begin
            // Falling back from write to read also aborts (dWEN is the live qualifier).
            if (dWEN) begin
               ramWEN   = 1'b1;
               ramaddr  = daddr;
               ramstore = dstore;
               if (ramready) begin
                  dwait   = 1'b0;
                  state_d = IDLE;
                  if (iREN && !starve_max) begin
                     starve_d = starve_q + CNT_W'(1);
                  end
               end
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef MEM_ARBITER_PERF_EN
   logic [31:0] icyc_q, dcyc_q;

   // Free-running stall counters; wrap naturally on overflow.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         icyc_q <= '0;
         dcyc_q <= '0;
      end else begin
         if (iREN && iwait) begin
            icyc_q <= icyc_q + 32'd1;
         end
         if ((dREN || dWEN) && dwait) begin
            dcyc_q <= dcyc_q + 32'd1;
         end
      end
   end

   assign icyc_wait = icyc_q;
   assign dcyc_wait = dcyc_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model of the arbitration rules.
// Stimulus changes 1 time unit after the rising edge; outputs are sampled on the falling edge.

module tb_mem_arbiter;

   localparam int unsigned W     = 32;
   localparam int unsigned LIMIT = 4;

   logic         CLK = 1'b0;
   logic         RST;
   logic         iREN, dREN, dWEN, ramready;
   logic [W-1:0] iaddr, daddr, dstore, ramload;
   logic [W-1:0] iload, dload, ramaddr, ramstore;
   logic         iwait, dwait, ramREN, ramWEN;
`ifdef MEM_ARBITER_PERF_EN
   logic [31:0]  icyc_wait, dcyc_wait;
`endif

   mem_arbiter #(.WORD_W(W), .STARVE_LIMIT(LIMIT)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
`ifdef MEM_ARBITER_PERF_EN
      .icyc_wait(icyc_wait), .dcyc_wait(dcyc_wait),
`endif
      .ramload(ramload), .ramready(ramready)
   );

   always #5 CLK = ~CLK;

   int    tests = 0;
   int    fails = 0;
   int    cyc   = 0;
   string cur   = "";

   // Reference model: who currently holds the RAM (0 nobody, 1 icache,
   // 2 dcache read, 3 dcache write) and how many dcache words have been
   // served back-to-back while the icache was asking.
   int          m_owner  = 0;
   int          m_starve = 0;
   int unsigned m_icyc   = 0;
   int unsigned m_dcyc   = 0;

   // Values seen on the last sampled falling edge.
   logic         s_iwait, s_dwait, s_ramREN, s_ramWEN;
   logic [W-1:0] s_iload, s_dload, s_ramaddr, s_ramstore;
   logic [31:0]  s_icyc, s_dcyc;

   task automatic step();
      logic         e_iwait, e_dwait, e_ren, e_wen, served_d;
      logic [W-1:0] e_iload, e_dload, e_addr, e_store;
      int           nxt;
      @(negedge CLK);
      cyc++;
      s_iwait = iwait;  s_dwait = dwait;  s_ramREN = ramREN;  s_ramWEN = ramWEN;
      s_iload = iload;  s_dload = dload;  s_ramaddr = ramaddr; s_ramstore = ramstore;
`ifdef MEM_ARBITER_PERF_EN
      s_icyc = icyc_wait; s_dcyc = dcyc_wait;
`else
      s_icyc = '0; s_dcyc = '0;
`endif
      e_iwait = 1'b1; e_dwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
      e_iload = '0; e_dload = '0; e_addr = '0; e_store = '0;
      served_d = 1'b0;
      nxt = m_owner;

      if (!RST) begin
         if (m_owner == 0) begin
            if (!iREN) m_starve = 0;
            if (iREN && m_starve == LIMIT) nxt = 1;
            else if (dWEN) nxt = 3;
            else if (dREN) nxt = 2;
            else if (iREN) nxt = 1;
         end else begin
            // Is the granted requester still asking for exactly what it was granted?
            logic live;
            live = (m_owner == 1) ? iREN : (m_owner == 2) ? (dREN && !dWEN) : dWEN;
            nxt = live && !ramready ? m_owner : 0;
            if (live) begin
               e_ren  = (m_owner != 3);
               e_wen  = (m_owner == 3);
               e_addr = (m_owner == 1) ? iaddr : daddr;
               if (m_owner == 3) e_store = dstore;
               if (ramready) begin
                  if (m_owner == 1) begin
                     e_iwait = 1'b0; e_iload = ramload; m_starve = 0;
                  end else begin
                     e_dwait = 1'b0; served_d = 1'b1;
                     if (m_owner == 2) e_dload = ramload;
                  end
               end
            end
         end
         if (served_d && iREN && m_starve < LIMIT) m_starve++;
      end

      tests++;
      if ({s_iwait, s_dwait} !== {e_iwait, e_dwait}) begin
         fails++;
         $display("FAIL %s waits cyc=%0d got i/d=%b%b expected %b%b", cur, cyc, s_iwait, s_dwait, e_iwait, e_dwait);
      end
      tests++;
      if ({s_iload, s_dload} !== {e_iload, e_dload}) begin
         fails++;
         $display("FAIL %s loads cyc=%0d got i=%h d=%h expected i=%h d=%h", cur, cyc, s_iload, s_dload, e_iload, e_dload);
      end
      tests++;
      if ({s_ramREN, s_ramWEN, s_ramaddr, s_ramstore} !== {e_ren, e_wen, e_addr, e_store}) begin
         fails++;
         $display("FAIL %s rambus cyc=%0d got ren=%b wen=%b a=%h s=%h expected ren=%b wen=%b a=%h s=%h",
                  cur, cyc, s_ramREN, s_ramWEN, s_ramaddr, s_ramstore, e_ren, e_wen, e_addr, e_store);
      end
`ifdef MEM_ARBITER_PERF_EN
      tests++;
      if ({s_icyc, s_dcyc} !== {(RST ? 32'd0 : m_icyc), (RST ? 32'd0 : m_dcyc)}) begin
         fails++;
         $display("FAIL %s perf cyc=%0d got i=%0d d=%0d expected i=%0d d=%0d", cur, cyc, s_icyc, s_dcyc,
                  RST ? 0 : m_icyc, RST ? 0 : m_dcyc);
      end
`endif
      if (RST) begin
         m_owner = 0; m_starve = 0; m_icyc = 0; m_dcyc = 0;
      end else begin
         m_owner = nxt;
         if (iREN && e_iwait) m_icyc++;
         if ((dREN || dWEN) && e_dwait) m_dcyc++;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      idle_inputs();
      step();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      cur = "reset";
      do_reset();
      tests++;
      if ({s_iwait, s_dwait, s_ramREN, s_ramWEN, s_ramaddr, s_iload, s_dload} !== {1'b1, 1'b1, 2'b00, {(3*W){1'b0}}}) begin
         fails++;
         $display("FAIL reset_values got iw=%b dw=%b ren=%b wen=%b a=%h expected 1 1 0 0 0", s_iwait, s_dwait, s_ramREN, s_ramWEN, s_ramaddr);
      end
   endtask

   task automatic test_read_latency();
      int ren_cnt = 0;
      int low_at  = 0;
      cur = "read_latency";
      do_reset();
      dREN = 1; daddr = 32'h40; ramload = 32'hCAFEF00D;
      for (int c = 1; c <= 4; c++) begin
         ramready = (c == 3);
         if (c == 4) dREN = 0;
         step();
         if (s_ramREN) ren_cnt++;
         if (!s_dwait && low_at == 0) begin
            low_at = c;
            tests++;
            if (s_dload !== 32'hCAFEF00D) begin
               fails++;
               $display("FAIL read_data got %h expected cafef00d", s_dload);
            end
         end
      end
      tests++;
      if (low_at != 3) begin
         fails++;
         $display("FAIL read_dwait_cycle got %0d expected 3", low_at);
      end
      tests++;
      if (ren_cnt != 2) begin
         fails++;
         $display("FAIL read_ren_cycles got %0d expected 2", ren_cnt);
      end
   endtask

   task automatic test_write_then_icache();
      cur = "write_then_i";
      do_reset();
      iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h3100; dstore = 32'h5;
      step();
      step();
      tests++;
      if ({s_ramWEN, s_ramREN, s_ramstore, s_ramaddr, s_iwait} !== {2'b10, 32'h5, 32'h3100, 1'b1}) begin
         fails++;
         $display("FAIL write_first got wen=%b ren=%b s=%h a=%h iw=%b expected 1 0 5 3100 1",
                  s_ramWEN, s_ramREN, s_ramstore, s_ramaddr, s_iwait);
      end
      ramready = 1;
      step();
      dWEN = 0; ramready = 0;
      step();
      step();
      tests++;
      if ({s_ramREN, s_ramaddr, s_iwait} !== {1'b1, 32'h80, 1'b1}) begin
         fails++;
         $display("FAIL i_after_write got ren=%b a=%h iw=%b expected 1 80 1", s_ramREN, s_ramaddr, s_iwait);
      end
      ramready = 1; ramload = 32'h1234_5678;
      step();
      tests++;
      if ({s_iwait, s_iload} !== {1'b0, 32'h1234_5678}) begin
         fails++;
         $display("FAIL i_complete got iw=%b d=%h expected 0 12345678", s_iwait, s_iload);
      end
      idle_inputs();
      step();
   endtask

   // Holds both sides requesting with an always-ready RAM and checks the
   // order in which words are served; 'i' only every (LIMIT+1)th word.
   task automatic check_service_order(input int n, input string name);
      byte got[$];
      for (int c = 0; c < 8 * n && got.size() < n; c++) begin
         step();
         if (!s_dwait) got.push_back("d");
         if (!s_iwait) got.push_back("i");
      end
      tests++;
      if (got.size() != n) begin
         fails++;
         $display("FAIL %s count got %0d expected %0d", name, got.size(), n);
      end
      for (int k = 0; k < got.size(); k++) begin
         byte exp;
         exp = ((k % (LIMIT + 1)) == LIMIT) ? "i" : "d";
         tests++;
         if (got[k] !== exp) begin
            fails++;
            $display("FAIL %s word%0d got %c expected %c", name, k, got[k], exp);
         end
      end
   endtask

   task automatic test_starvation();
      cur = "starvation";
      do_reset();
      iREN = 1; dREN = 1; ramready = 1; iaddr = 32'h100; daddr = 32'h200; ramload = 32'hA5;
      check_service_order(10, "starve_order");
      idle_inputs();
      step();
   endtask

   task automatic test_abort();
      cur = "abort";
      do_reset();
      iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h88;
      step();
      step();
      dREN = 0;
      step();
      tests++;
      if ({s_ramREN, s_dwait} !== 2'b01) begin
         fails++;
         $display("FAIL abort_strobe got ren=%b dw=%b expected 0 1", s_ramREN, s_dwait);
      end
      step();
      step();
      tests++;
      if ({s_ramREN, s_ramaddr} !== {1'b1, 32'h44}) begin
         fails++;
         $display("FAIL abort_then_i got ren=%b a=%h expected 1 44", s_ramREN, s_ramaddr);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_reset_mid();
      cur = "reset_mid";
      do_reset();
      iREN = 1; dREN = 1; ramready = 1;
      for (int c = 0; c < 6; c++) step();
      dREN = 0; dWEN = 1; daddr = 32'h77; ramready = 0;
      step();
      #1;
      tests++;
      if (ramWEN !== 1'b1) begin
         fails++;
         $display("FAIL rst_pre_dwr got wen=%b expected 1", ramWEN);
      end
      RST = 1'b1;
      #1;
      tests++;
      if ({ramWEN, ramaddr, dwait} !== {1'b0, 32'h0, 1'b1}) begin
         fails++;
         $display("FAIL rst_async got wen=%b a=%h dw=%b expected 0 0 1", ramWEN, ramaddr, dwait);
      end
      step();
      RST = 1'b0;
      dWEN = 0; dREN = 1; ramready = 1;
      check_service_order(5, "rst_starve_cleared");
      idle_inputs();
      step();
   endtask

`ifdef MEM_ARBITER_PERF_EN
   task automatic test_perf();
      cur = "perf";
      do_reset();
      iREN = 1; iaddr = 32'h10;
      for (int c = 1; c <= 10; c++) begin
         ramready = (c == 10);
         step();
      end
      idle_inputs();
      step();
      tests++;
      if (s_icyc !== 32'd9) begin
         fails++;
         $display("FAIL perf_icyc got %0d expected 9", s_icyc);
      end
   endtask
`endif

   task automatic test_random();
      cur = "random";
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) iREN = $urandom_range(0, 1);
         if ($urandom_range(0, 3) == 0) dREN = $urandom_range(0, 1);
         if ($urandom_range(0, 5) == 0) dWEN = ($urandom_range(0, 2) == 0);
         ramready = ($urandom_range(0, 2) == 0);
         iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
         RST = ($urandom_range(0, 299) == 0);
         step();
         RST = 1'b0;
      end
      idle_inputs();
      step();
   endtask

   initial begin
      RST = 1'b1;
      idle_inputs();
      #1;
      test_reset();
      test_read_latency();
      test_write_then_icache();
      test_starvation();
      test_abort();
      test_reset_mid();
`ifdef MEM_ARBITER_PERF_EN
      test_perf();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
